// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with per-key debounce and signed decimal operand entry.
// Digits build a magnitude/sign pair bounded to the display range -999..+9999.
module keypad_entry #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  col_i,
   output logic [3:0]  row_o,
   output logic        key_valid_o,
   output logic [3:0]  key_code_o,
   output logic        op_valid_o,
   output logic [1:0]  op_code_o,
   output logic [15:0] entry_value_o,
   output logic        entry_rej_o
);

   // state    | meaning
   // ST_SCAN  | drive row k for SCAN_DIV cycles, sample columns on the last one
   // ST_DEB   | row k held, count consecutive low cycles on column c
   // ST_HELD  | key accepted, wait for DEBOUNCE_CYCLES cycles of all columns high
   typedef enum logic [1:0] {
      ST_SCAN = 2'd0,
      ST_DEB  = 2'd1,
      ST_HELD = 2'd2
   } state_t;

   localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    col_s1_q, cs_q;
   state_t        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic [1:0]    c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          op_valid_q, op_valid_d;
   logic [1:0]    op_code_q, op_code_d;
   logic [13:0]   mag_q, mag_d;
   logic          neg_q, neg_d;
   logic          rej_q, rej_d;

   logic [1:0]    low_idx;
   logic [3:0]    code_now;
   logic [16:0]   mul10;
   logic [16:0]   cand;
   logic [16:0]   limit;
   logic [15:0]   mag_ext;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   always_comb begin
      low_idx = 2'd3;
      if (!cs_q[0])      low_idx = 2'd0;
      else if (!cs_q[1]) low_idx = 2'd1;
      else if (!cs_q[2]) low_idx = 2'd2;
   end

   assign code_now = key_map(k_q, c_q);

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      c_d         = c_q;
      cnt_d       = cnt_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      op_valid_d  = 1'b0;
      op_code_d   = op_code_q;
      case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (cs_q != 4'hF) begin
                  c_d     = low_idx;
                  state_d = ST_DEB;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DEB: begin
            if (cs_q[c_q]) begin
               cnt_d   = '0;
               k_d     = k_q + 2'd1;
               state_d = ST_SCAN;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d       = '0;
               key_valid_d = 1'b1;
               key_code_d  = code_now;
               state_d     = ST_HELD;
               // A..D occupy codes 10..13 contiguously
               if (code_now >= 4'hA && code_now <= 4'hD) begin
                  op_valid_d = 1'b1;
                  op_code_d  = 2'(code_now - 4'hA);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (cs_q != 4'hF) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d   = '0;
               k_d     = k_q + 2'd1;
               state_d = ST_SCAN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_SCAN;
         end
      endcase
   end

   assign mul10 = ({3'b000, mag_q} << 3) + ({3'b000, mag_q} << 1);
   assign cand  = mul10 + {13'd0, key_code_q};
   assign limit = neg_q ? 17'd999 : 17'd9999;

   always_comb begin
      mag_d = mag_q;
      neg_d = neg_q;
      rej_d = 1'b0;
      if (key_valid_q) begin
         if (key_code_q <= 4'd9) begin
            if (cand <= limit) mag_d = cand[13:0];
            else               rej_d = 1'b1;
         end else if (key_code_q == 4'hF) begin
            if (mag_q <= 14'd999) neg_d = ~neg_q;
            else                  rej_d = 1'b1;
         end else begin
            mag_d = '0;
            neg_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         col_s1_q    <= 4'hF;
         cs_q        <= 4'hF;
         state_q     <= ST_SCAN;
         k_q         <= 2'd0;
         c_q         <= 2'd0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         op_valid_q  <= 1'b0;
         op_code_q   <= 2'd0;
         mag_q       <= '0;
         neg_q       <= 1'b0;
         rej_q       <= 1'b0;
      end else begin
         col_s1_q    <= col_i;
         cs_q        <= col_s1_q;
         state_q     <= state_d;
         k_q         <= k_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         op_valid_q  <= op_valid_d;
         op_code_q   <= op_code_d;
         mag_q       <= mag_d;
         neg_q       <= neg_d;
         rej_q       <= rej_d;
      end
   end

   assign mag_ext       = {2'b00, mag_q};
   assign row_o         = ~(4'b0001 << k_q);
   assign key_valid_o   = key_valid_q;
   assign key_code_o    = key_code_q;
   assign op_valid_o    = op_valid_q;
   assign op_code_o     = op_code_q;
   assign entry_value_o = neg_q ? (16'd0 - mag_ext) : mag_ext;
   assign entry_rej_o   = rej_q;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the 4-digit display driver. Scans a 4x4 matrix keypad, debounces each key, and assembles decimal key presses into a 16-bit two's-complement operand.
- `entry_value` feeds the display driver's `data_in` directly. Operator keys are passed to the calculator core as one-cycle pulses.
- Entered values are limited to the display's range: -999..+9999.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven before its columns are sampled (≥4).
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release (≥2).

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  synchronous reset, active low
- col  in  4  keypad columns, active low, externally pulled up, asynchronous
- row  out  4  keypad row drive, active low, exactly one bit low
- key_valid  out  1  one-cycle pulse per accepted key press
- key_code  out  4  code of the last accepted key, held until the next accepted key
- op_valid  out  1  one-cycle pulse, coincident with key_valid, for keys A–D
- op_code  out  2  A=0, B=1, C=2, D=3; valid while op_valid is high
- entry_value  out  16  signed operand being entered
- entry_rej  out  1  one-cycle pulse when a digit or sign key is rejected

Behaviour:
- Column synchronisation:
  - `col` passes through a 2-flop synchroniser; all logic uses the synchronised `cs`.
  - `cs` lags the pins by 2 cycles.
- Key map, row r / column c → key_code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- Reset values:
  - row=4'b1110, state=SCAN, all counters 0.
  - key_valid=0, key_code=0, op_valid=0, op_code=0, entry_rej=0.
  - Magnitude=0, sign=positive, so entry_value=0.
- FSM, state SCAN:
  - Row index k is driven for SCAN_DIV cycles.
  - On the last dwell cycle, sample `cs`:
    - If any bit is low, latch k and the lowest-index low column c, zero the counter, and go to DEBOUNCE.
    - Otherwise advance k (wraps 3→0) and restart the dwell.
- FSM, state DEBOUNCE:
  - Row k stays driven.
  - Each cycle with `cs[c]`=0, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1: assert key_valid for 1 cycle, update key_code, go to HELD.
  - If `cs[c]`=1 in any cycle: no output, advance to row k+1, go to SCAN.
- FSM, state HELD:
  - Row k stays driven.
  - The counter counts consecutive cycles with `cs`==4'hF and clears on any low bit.
  - At DEBOUNCE_CYCLES-1, go to SCAN at row k+1.
  - Holding a key never repeats; a second key pressed during HELD is ignored until all keys are released.
- Entry logic (registered; state is magnitude M and sign S; updates the cycle after key_valid):
  - Digit d, candidate N = M*10 + d:
    - Accept if N ≤ 9999 when S=+, or N ≤ 999 when S=−.
    - Otherwise M is unchanged and entry_rej pulses.
    - 0 pressed with M=0 leaves M=0 and is not a reject.
  - F(#), sign toggle:
    - Allowed if M ≤ 999; otherwise reject with entry_rej.
    - Toggling with M=0 is permitted and sets the sign only; entry_value stays 0.
  - E(*): M=0, S=+.
  - A–D: op_valid/op_code pulse; after the pulse, M=0 and S=+ so the next operand starts fresh.
- Output value:
  - entry_value = S ? −M : M, 16-bit two's complement.
  - The ×10 multiply is computed as (M<<3)+(M<<1) in ≥17 bits before comparison.
- Timing:
  - key_valid and op_valid are coincident.
  - entry_value and entry_rej are valid 1 cycle after key_valid.
- Reset mid-operation (debounce or held): immediate return to reset values. A key still held after reset is re-detected and debounced as a new press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Press key at r1/c2, hold 60 cycles, release 20 → row scans to 4'b1101; exactly one key_valid with key_code=6; entry_value=6; scanning resumes at row 4'b1011.
- Bounce: assert the key for 5 cycles, release for 2, repeat 3 times, then hold stable → no key_valid during bounce; exactly one key_valid after 8 stable cycles.
- Press 1,2,3,4,5 → entry_value 1, 12, 123, 1234; 5th press gives entry_rej=1 and entry_value stays 1234 (16'h04D2).
- Press 7,5, then #, then 3 → entry_value 75, then −75 (16'hFFB5), then −753 (16'hFD0F); a further digit 1 → entry_rej, value stays −753.
- Press 9,9,9,9 then # → entry_rej, value 9999; press * → 0; press B → op_valid=1, op_code=1 coincident with key_valid; entry_value 0.
- Simultaneous keys at r0/c1 and r0/c3 → key_code=2 only. Assert rst_n=0 during HELD → row=4'b1110 and entry_value=0 next cycle.
